// File: rtl/itr_ctrl_if.sv
// IO bus between the core and its IO peripherals: write strobe/address/data
// plus a registered read address with combinational read data back.
interface itr_ctrl_if #(
  parameter int NUBITS = 32,
  parameter int NBIOA  = 3
);
  logic              io_wr;
  logic [NBIOA-1:0]  io_addr_w;
  logic [NUBITS-1:0] io_wdata;
  logic [NBIOA-1:0]  io_addr_r;
  logic [NUBITS-1:0] io_rdata;

  modport master (output io_wr, io_addr_w, io_wdata, io_addr_r, input io_rdata);
  modport slave  (input io_wr, io_addr_w, io_wdata, io_addr_r, output io_rdata);
endinterface

// File: rtl/itr_ctrl.sv
// Multi-source interrupt controller feeding the core's single itr input.
// Rising edges on src are latched into pnd, masked by msk, and the lowest
// eligible index is delivered as a one-cycle itr pulse. Further interrupts
// are held off until the ISR writes EOI, followed by GAP idle cycles.
module itr_ctrl #(
  parameter int NSRC   = 4,
  parameter int NUBITS = 32,
  parameter int NBIOA  = 3,
  parameter int A_MSK  = 0,
  parameter int A_PND  = 1,
  parameter int A_VEC  = 2,
  parameter int A_EOI  = 3,
  parameter int GAP    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  itr_ctrl_if.slave       bus,
  output logic            itr,
  output logic            busy
);

  localparam int VW = (NSRC > 1) ? $clog2(NSRC) : 1;

  localparam logic [NBIOA-1:0] AD_MSK = NBIOA'(A_MSK);
  localparam logic [NBIOA-1:0] AD_PND = NBIOA'(A_PND);
  localparam logic [NBIOA-1:0] AD_VEC = NBIOA'(A_VEC);
  localparam logic [NBIOA-1:0] AD_EOI = NBIOA'(A_EOI);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FIRE = 2'd1;
  localparam logic [1:0] S_SERV = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  // Counter preload; only meaningful when GAP > 0.
  localparam logic [3:0] GAP_LD = 4'(GAP - 1);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] pnd_q, pnd_d;
  logic [NSRC-1:0] msk_q, msk_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [1:0]      st_q, st_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            wr_msk, wr_pnd, wr_eoi;
  logic [NSRC-1:0] rise, clr, elig, take;
  logic [VW-1:0]   win;
  logic            any;
  logic [NUBITS-1:0] rdata;

  // Upper write-data bits carry nothing for this block.
  if (NUBITS > NSRC) begin : g_unused
    logic unused_wdata;
    assign unused_wdata = ^bus.io_wdata[NUBITS-1:NSRC];
  end

  // Write decode and edge detection.
  always_comb begin
    wr_msk = bus.io_wr && (bus.io_addr_w == AD_MSK);
    wr_pnd = bus.io_wr && (bus.io_addr_w == AD_PND);
    wr_eoi = bus.io_wr && (bus.io_addr_w == AD_EOI);
    rise   = src & ~src_q;
    clr    = wr_pnd ? bus.io_wdata[NSRC-1:0] : '0;
    elig   = pnd_q & msk_q;
  end

  // Fixed priority: scan high to low so the lowest set index is left in win.
  always_comb begin
    win = '0;
    any = |elig;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) win = VW'(i);
    end
  end

  // Next-state logic for the FSM, vector latch and hold-off counter.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    vec_d = vec_q;
    take  = '0;
    case (st_q)
      S_IDLE: begin
        if (any) begin
          st_d      = S_FIRE;
          vec_d     = win;
          take[win] = 1'b1;
        end
      end
      S_FIRE: st_d = S_SERV;
      S_SERV: begin
        if (wr_eoi) begin
          if (GAP == 0) begin
            st_d = S_IDLE;
          end else begin
            st_d  = S_HOLD;
            cnt_d = GAP_LD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) st_d = S_IDLE;
        else               cnt_d = cnt_q - 4'd1;
      end
      default: st_d = S_IDLE;
    endcase
    // New edges win over both software clear and the service handoff.
    pnd_d = (pnd_q & ~clr & ~take) | rise;
    msk_d = wr_msk ? bus.io_wdata[NSRC-1:0] : msk_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_q <= '0;
      pnd_q <= '0;
      msk_q <= '0;
      vec_q <= '0;
      st_q  <= S_IDLE;
      cnt_q <= '0;
    end else begin
      src_q <= src;
      pnd_q <= pnd_d;
      msk_q <= msk_d;
      vec_q <= vec_d;
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  assign itr  = (st_q == S_FIRE);
  assign busy = (st_q == S_FIRE) || (st_q == S_SERV);

  // Combinational read mux; unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    case (bus.io_addr_r)
      AD_MSK: rdata[NSRC-1:0] = msk_q;
      AD_PND: rdata[NSRC-1:0] = pnd_q;
      AD_VEC: rdata[VW-1:0]   = vec_q;
      AD_EOI: rdata[2:0]      = {busy, st_q};
      default: rdata = '0;
    endcase
  end

  assign bus.io_rdata = rdata;

endmodule

// File: tb/tb_itr_ctrl.sv
// Directed bench for itr_ctrl: stimulus pushes expected itr cycles and read
// values into queues; the negedge monitor pops and compares.
module tb_itr_ctrl;
  localparam logic [2:0] A_MSK = 3'd0;
  localparam logic [2:0] A_PND = 3'd1;
  localparam logic [2:0] A_VEC = 3'd2;
  localparam logic [2:0] A_EOI = 3'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src;
  logic       itr, busy;

  itr_ctrl_if #(.NUBITS(32), .NBIOA(3)) bus ();

  itr_ctrl #(
    .NSRC(4), .NUBITS(32), .NBIOA(3),
    .A_MSK(0), .A_PND(1), .A_VEC(2), .A_EOI(3), .GAP(2)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .src  (src),
    .bus  (bus),
    .itr  (itr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          exp_itr[$];
  logic [31:0] exp_rd[$];
  logic [2:0]  adr_rd[$];
  string       nm_rd[$];
  logic        rd_req = 1'b0;
  logic        done   = 1'b0;
  int          n_cmp  = 0;
  int          n_bad  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    bus.io_wr     = 1'b1;
    bus.io_addr_w = a;
    bus.io_wdata  = d;
    tick();
    bus.io_wr     = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    bus.io_addr_r = a;
    exp_rd.push_back(e);
    adr_rd.push_back(a);
    nm_rd.push_back(nm);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: compare reads and itr pulses against the queued expectations.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [2:0]  a;
    string       nm;
    int          c;
    if (rd_req) begin
      e  = exp_rd.pop_front();
      a  = adr_rd.pop_front();
      nm = nm_rd.pop_front();
      n_cmp++;
      if (bus.io_rdata !== e) begin
        n_bad++;
        $display("FAIL %s: io_rdata=%h expected %h (cycle %0d)", nm, bus.io_rdata, e, cyc);
      end
      if (a == A_EOI) begin
        n_cmp++;
        if (busy !== e[2]) begin
          n_bad++;
          $display("FAIL %s_busy: busy=%b expected %b (cycle %0d)", nm, busy, e[2], cyc);
        end
      end
    end
    if (itr !== 1'b0) begin
      n_cmp++;
      if (exp_itr.size() == 0) begin
        n_bad++;
        $display("FAIL itr_unexpected: itr=%b at cycle %0d, none expected", itr, cyc);
      end else begin
        c = exp_itr.pop_front();
        if (c != cyc) begin
          n_bad++;
          $display("FAIL itr_cycle: itr at cycle %0d expected cycle %0d", cyc, c);
        end
      end
    end
    if (!done && cyc > 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: stimulus not finished by cycle %0d", cyc);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
    if (done) begin
      n_cmp++;
      if (exp_itr.size() != 0) begin
        n_bad++;
        $display("FAIL itr_missing: %0d expected pulses never seen, expected 0", exp_itr.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    src = 4'h0;
    bus.io_wr     = 1'b0;
    bus.io_addr_w = 3'd0;
    bus.io_wdata  = 32'h0;
    bus.io_addr_r = 3'd0;

    // Asynchronous reset asserted mid-cycle.
    #2 rst = 1'b0;
    tick(); tick();
    rd(A_MSK, 32'h0, "rst_msk");
    rd(A_PND, 32'h0, "rst_pnd");
    rd(A_VEC, 32'h0, "rst_vec");
    rd(A_EOI, 32'h0, "rst_stat");
    rst = 1'b1;
    tick();

    // Masked source is captured but never fires; EOI/VEC/unmapped writes do nothing.
    src = 4'b0001; tick(); src = 4'h0; tick(); tick();
    rd(A_PND, 32'h1, "masked_pnd");
    wr(A_EOI, 32'h0);
    wr(A_VEC, 32'h1);
    wr(3'd5, 32'hF);
    rd(A_EOI, 32'h0, "idle_eoi_ignored");
    rd(A_VEC, 32'h0, "vec_ro");
    rd(A_MSK, 32'h0, "unmapped_wr");
    rd(3'd6, 32'h0, "unmapped_rd");
    wr(A_PND, 32'h1);
    rd(A_PND, 32'h0, "w1c_clear");

    // Single interrupt on src[2].
    wr(A_MSK, 32'hF);
    src = 4'b0100; t = cyc; exp_itr.push_back(t + 2);
    tick(); src = 4'h0; tick();
    rd(A_EOI, 32'h5, "fire_stat");
    rd(A_EOI, 32'h6, "serv_stat");
    rd(A_VEC, 32'h2, "single_vec");
    rd(A_PND, 32'h0, "single_pnd");
    wr(A_EOI, 32'h0);
    rd(A_EOI, 32'h3, "hold_stat0");
    rd(A_EOI, 32'h3, "hold_stat1");
    rd(A_EOI, 32'h0, "gap_idle");

    // Priority: src[3] and src[1] together.
    src = 4'b1010; t = cyc; exp_itr.push_back(t + 2);
    tick(); src = 4'h0; tick(); tick();
    rd(A_VEC, 32'h1, "prio_vec1");
    rd(A_PND, 32'h8, "prio_pnd");
    t = cyc; exp_itr.push_back(t + 4);
    wr(A_EOI, 32'h0);
    repeat (4) tick();
    rd(A_VEC, 32'h3, "prio_vec3");
    rd(A_PND, 32'h0, "prio_pnd_empty");
    wr(A_EOI, 32'h0);
    repeat (3) tick();

    // No re-fire without EOI: src[0] pulsed five times in service.
    src = 4'b0100; t = cyc; exp_itr.push_back(t + 2);
    tick(); src = 4'h0; tick(); tick();
    for (int k = 0; k < 5; k++) begin
      src = 4'b0001; tick(); src = 4'h0; tick();
    end
    rd(A_PND, 32'h1, "refire_pnd");
    rd(A_EOI, 32'h6, "refire_serv");
    t = cyc; exp_itr.push_back(t + 4);
    wr(A_EOI, 32'h0);
    repeat (4) tick();
    rd(A_VEC, 32'h0, "refire_vec");
    wr(A_EOI, 32'h0);
    repeat (3) tick();
    rd(A_EOI, 32'h0, "refire_idle");

    // W1C race: edge and clear on the same bit in the same cycle.
    wr(A_MSK, 32'h0);
    src = 4'b0010;
    bus.io_wr = 1'b1; bus.io_addr_w = A_PND; bus.io_wdata = 32'h2;
    tick();
    bus.io_wr = 1'b0; src = 4'h0;
    rd(A_PND, 32'h2, "race_set_wins");
    wr(A_PND, 32'h2);
    rd(A_PND, 32'h0, "race_later_clear");

    // Masked pending bit fires once unmasked; upper write bits ignored.
    src = 4'b1000; tick(); src = 4'h0; tick();
    rd(A_PND, 32'h8, "held_pending");
    t = cyc; exp_itr.push_back(t + 2);
    wr(A_MSK, 32'hABCD_EF08);
    tick(); tick();
    rd(A_MSK, 32'h8, "msk_narrow");
    rd(A_VEC, 32'h3, "unmask_vec");
    wr(A_MSK, 32'hF);
    rd(A_VEC, 32'h3, "msk_in_serv_vec");

    // Own source re-asserts in service, then reset mid-service.
    src = 4'b1000; tick(); src = 4'h0; tick();
    rd(A_PND, 32'h8, "serv_repend");
    #2 rst = 1'b0;
    rd(A_EOI, 32'h0, "midrst_stat");
    rst = 1'b1;
    rd(A_PND, 32'h0, "midrst_pnd");
    rd(A_MSK, 32'h0, "midrst_msk");
    rd(A_VEC, 32'h0, "midrst_vec");
    wr(A_EOI, 32'h0);
    repeat (5) tick();
    rd(A_EOI, 32'h0, "midrst_eoi_ignored");

    done = 1'b1;
  end
endmodule

// File: doc/itr_ctrl.md
Name: itr_ctrl

Overview:
- Multi-source interrupt controller in front of the single `itr` input of the fixed-point core.
- Captures rising edges from NSRC peripheral request lines and applies a software-writable mask.
- Selects the highest-priority pending source (lowest index wins), issues a one-cycle `itr` pulse, then holds off further interrupts until the ISR writes end-of-interrupt (EOI).
- Connects to the core's IO bus alongside other IO peripherals: writes via `out_en`/`addr_out`/`data_out`, reads via `req_in`/`addr_in`/`io_in`.

Parameters:
- NSRC, 4, number of interrupt sources (1..16).
- NUBITS, 32, IO data width.
- NBIOA, 3, IO address width.
- A_MSK, 0, IO address of the mask register (read/write).
- A_PND, 1, IO address of the pending register (read; write-1-to-clear).
- A_VEC, 2, IO address of the vector register (read only; index of in-service source).
- A_EOI, 3, IO address of EOI (write, data ignored).
- GAP, 2, minimum idle cycles after EOI before the next `itr` pulse (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- src  in  NSRC  interrupt request lines, synchronous to clk, active high.
- io_wr  in  1  IO write strobe (core `out_en`).
- io_addr_w  in  NBIOA  IO write address.
- io_wdata  in  NUBITS  IO write data.
- io_addr_r  in  NBIOA  IO read address (core `addr_in`, already registered in the core).
- io_rdata  out  NUBITS  IO read data, combinational from io_addr_r.
- itr  out  1  interrupt pulse to the core.
- busy  out  1  high while an interrupt is in service.

Behaviour:
- Reset (rst=0, asynchronous):
  - src_q=0, pnd=0, msk=0 (all sources masked), vec=0, gap counter=0, state=IDLE.
  - itr=0, busy=0.
- Edge capture, every cycle: rise = src & ~src_q; src_q <= src.
  - pnd <= (pnd & ~clr) | rise.
  - clr = io_wdata[NSRC-1:0] when io_wr && io_addr_w==A_PND, otherwise 0.
  - Set wins over clear on the same bit in the same cycle.
  - A held-high src produces only one pending bit.
- Eligible = pnd & msk. Winner = lowest set index of eligible.
- FSM states: IDLE, FIRE, SERV, HOLD.
  - IDLE: if eligible!=0, go to FIRE; in the same clock, latch vec <= winner and clear pnd[winner].
  - FIRE: itr=1 for exactly this one cycle, busy=1; go to SERV unconditionally.
  - SERV: busy=1, itr=0. On io_wr && io_addr_w==A_EOI: if GAP==0 go to IDLE, else load counter=GAP-1 and go to HOLD.
  - HOLD: busy=0. Counter decrements each cycle; go to IDLE when counter==0. Effective spacing is GAP cycles from EOI to IDLE.
- Latency: src rising at edge N sets pnd at edge N+1 → FIRE entered at N+2 → itr high during the cycle after edge N+2 (when masked-in and IDLE).
- Boundary conditions:
  - EOI written in IDLE/FIRE/HOLD: ignored.
  - EOI and new src edge in the same cycle: the edge is still captured into pnd.
  - A source re-asserting while in service (including its own index): sets pnd again and is serviced after EOI+GAP.
  - Writing msk during SERV does not affect the in-service vec; it only affects future selection.
  - Masking a pending bit keeps it pending. It fires when unmasked.
  - Write to A_VEC or an unmapped address: no effect.
  - Reset mid-SERV returns everything to the reset values; the in-service source is lost.
- Reads (io_rdata, combinational):
  - A_MSK → msk, zero-extended.
  - A_PND → pnd, zero-extended.
  - A_VEC → vec (clog2(NSRC) bits), zero-extended.
  - A_EOI → {busy, state[1:0]} in bits [2:0].
  - Other addresses → 0.
- Widths: only io_wdata[NSRC-1:0] is used. Upper write bits are ignored.

Test Plan:
- Reset check: rst low asynchronously mid-cycle → itr=0, busy=0; io_rdata=0 at A_MSK, A_PND and A_VEC. After release, pulse src=4'b0001 with msk=0 → no itr; read A_PND → 1.
- Single interrupt: write msk=4'hF, pulse src[2] for one cycle at edge N → itr high for exactly one cycle after edge N+2; busy=1; read A_VEC → 2; A_PND → 0.
- Priority: src[3] and src[1] rise in the same cycle → first vec=1. EOI, then GAP=2 idle cycles, then itr again with vec=3.
- No re-fire without EOI: in SERV, pulse src[0] five times → exactly one further itr, and only after EOI+GAP; A_PND reads 1 while in SERV.
- W1C race: src[1] rises in the same cycle as a write of 4'b0010 to A_PND → pnd[1] stays 1. A later write of 4'b0010 alone clears it.
- Reset mid-service: in SERV with pnd=4'b1000, drive rst=0 for one cycle → busy=0, pnd=0, msk=0. A subsequent EOI write has no effect and no itr is issued.
